// File: rtl/usb_rx_nrzi.sv
// usb_rx_nrzi: receive-side USB line decoder.
// Takes the line receiver's J/K level each clock, NRZI-decodes it, locks onto
// SYNC, strips stuffed zeros and delivers framed serial data bits to the
// packet parser, with start/end strobes.
//
// Optional feature macro: USB_RX_ERR_EN
//   defined   -> stuff_err / align_err are live; a stuff violation drops the packet.
//   undefined -> both error outputs stay 0; a stuff violation bit is discarded
//                like a stuffed 0 and the packet carries on.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | line quiet, prev_lvl held at J, waiting for first level
// S_SYNC     | counting decoded zeros until the SYNC-terminating 1
// S_DATA     | delivering unstuffed data bits
// S_DROP     | bad SYNC or stuff violation; ignore line until EOP
// S_EOP_WAIT | EOP on the line; wait for it to clear before going idle

module usb_rx_nrzi #(
    parameter int SYNC_ZEROS = 6,
    parameter int STUFF_LEN  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_eop,
    output logic data_bit,
    output logic data_valid,
    output logic pkt_start,
    output logic pkt_end,
    output logic stuff_err,
    output logic align_err,
    output logic busy
);

    localparam int              OW        = $clog2(STUFF_LEN + 1);
    localparam logic [2:0]      SYNC_MIN  = 3'(SYNC_ZEROS);
    localparam logic [OW-1:0]   STUFF_MAX = OW'(STUFF_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_DROP,
        S_EOP_WAIT
    } state_t;

    state_t        state, state_nx;
    logic          prev_lvl, prev_nx;
    logic [2:0]    zcnt, zcnt_nx;
    logic [OW-1:0] ones, ones_nx;
    logic [2:0]    bcnt, bcnt_nx;
    logic          started, started_nx;

    logic dv_nx, db_nx, ps_nx, pe_nx, se_nx, ae_nx;

    logic take_bit;
    logic dec;

    // in_eop always wins over in_valid; decoded 1 means no level transition.
    assign take_bit = in_valid & ~in_eop;
    assign dec      = (in_bit == prev_lvl);

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_lvl   <= 1'b1;
            zcnt       <= '0;
            ones       <= '0;
            bcnt       <= '0;
            started    <= 1'b0;
            data_bit   <= 1'b0;
            data_valid <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_end    <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_lvl   <= prev_nx;
            zcnt       <= zcnt_nx;
            ones       <= ones_nx;
            bcnt       <= bcnt_nx;
            started    <= started_nx;
            data_bit   <= db_nx;
            data_valid <= dv_nx;
            pkt_start  <= ps_nx;
            pkt_end    <= pe_nx;
            stuff_err  <= se_nx;
            align_err  <= ae_nx;
            busy       <= (state_nx != S_IDLE);
        end
    end

    // Next-state, counter updates and output strobes.
    always_comb begin
        state_nx   = state;
        prev_nx    = prev_lvl;
        zcnt_nx    = zcnt;
        ones_nx    = ones;
        bcnt_nx    = bcnt;
        started_nx = started;
        dv_nx      = 1'b0;
        db_nx      = 1'b0;
        ps_nx      = 1'b0;
        pe_nx      = 1'b0;
        se_nx      = 1'b0;
        ae_nx      = 1'b0;

        if (take_bit) begin
            prev_nx = in_bit;
        end

        case (state)
            S_IDLE: begin
                if (in_eop) begin
                    state_nx = S_EOP_WAIT;
                end else if (in_valid) begin
                    // The opening level already counts toward SYNC.
                    state_nx = S_SYNC;
                    zcnt_nx  = dec ? 3'd0 : 3'd1;
                end
            end

            S_SYNC: begin
                if (in_eop) begin
                    state_nx = S_EOP_WAIT;
                end else if (in_valid) begin
                    if (!dec) begin
                        zcnt_nx = (zcnt == 3'd7) ? 3'd7 : zcnt + 3'd1;
                    end else if (zcnt >= SYNC_MIN) begin
                        // SYNC's trailing 1 is the first of a possible stuff run.
                        state_nx   = S_DATA;
                        ones_nx    = OW'(1);
                        bcnt_nx    = 3'd0;
                        started_nx = 1'b0;
                    end else begin
                        state_nx = S_DROP;
                    end
                end
            end

            S_DATA: begin
                if (in_eop) begin
                    state_nx = S_EOP_WAIT;
                    pe_nx    = 1'b1;
`ifdef USB_RX_ERR_EN
                    ae_nx    = (bcnt != 3'd0);
`endif
                end else if (in_valid) begin
                    if (ones == STUFF_MAX) begin
                        // Stuffed position: the bit is never delivered.
                        ones_nx = '0;
`ifdef USB_RX_ERR_EN
                        if (dec) begin
                            se_nx    = 1'b1;
                            state_nx = S_DROP;
                        end
`endif
                    end else begin
                        dv_nx      = 1'b1;
                        db_nx      = dec;
                        ps_nx      = ~started;
                        started_nx = 1'b1;
                        bcnt_nx    = bcnt + 3'd1;
                        ones_nx    = dec ? ones + OW'(1) : '0;
                    end
                end
            end

            S_DROP: begin
                if (in_eop) begin
                    state_nx = S_EOP_WAIT;
                end
            end

            S_EOP_WAIT: begin
                if (!in_eop) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Every return to idle re-arms the decoder for a fresh packet.
        if (state_nx == S_IDLE) begin
            prev_nx = 1'b1;
            zcnt_nx = '0;
            ones_nx = '0;
            bcnt_nx = '0;
        end
    end

endmodule

// File: tb/tb_usb_rx_nrzi.sv
// Directed bench for usb_rx_nrzi: a hand-computed vector table for a basic
// 0xA5 packet, then scripted sequences for stuffing, sync failure, alignment
// and mid-packet reset. Expectations follow the USB_RX_ERR_EN build setting.

module tb_usb_rx_nrzi;

`ifdef USB_RX_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_bit, in_valid, in_eop;
    logic data_bit, data_valid, pkt_start, pkt_end, stuff_err, align_err, busy;

    logic [6:0] obs;
    logic       lvl;
    int         errors = 0;
    int         checks = 0;

    usb_rx_nrzi #(.SYNC_ZEROS(6), .STUFF_LEN(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_eop     (in_eop),
        .data_bit   (data_bit),
        .data_valid (data_valid),
        .pkt_start  (pkt_start),
        .pkt_end    (pkt_end),
        .stuff_err  (stuff_err),
        .align_err  (align_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign obs = {data_valid, data_bit, pkt_start, pkt_end, stuff_err, align_err, busy};

    typedef struct {
        logic       v;
        logic       e;
        logic       b;
        logic [6:0] exp;  // {dv, db, ps, pe, se, ae, busy}
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of line inputs, then sample just after the edge.
    task automatic step(input logic v, input logic e, input logic b);
        in_valid = v;
        in_eop   = e;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    // Send one decoded bit: 0 toggles the line level, 1 holds it.
    task automatic dec_bit(input logic d);
        if (!d) lvl = ~lvl;
        step(1'b1, 1'b0, lvl);
    endtask

    // Seven decoded zeros then a 1, starting from idle J.
    task automatic sync_seq();
        lvl = 1'b1;
        repeat (7) dec_bit(1'b0);
        dec_bit(1'b1);
    endtask

    task automatic end_pkt();
        step(1'b0, 1'b0, 1'b1);
        chk("return_idle", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] byte_v;
        logic       b;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_eop   = 1'b0;
        in_bit   = 1'b1;
        lvl      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", obs, 7'b0);
        rst = 1'b0;

        // SYNC = K J K J K J K K, then 0xA5 LSB-first, EOP, idle, EOP-from-idle.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 7'b0000000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 7'b0000001};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 7'b0000001};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 7'b0000001};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 7'b0000001};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 7'b0000001};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 7'b0000001};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 7'b0000001};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 7'b0000001};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 7'b1110001};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 7'b1000001};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 7'b1100001};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 7'b1000001};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 7'b1000001};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 7'b1100001};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 7'b1000001};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 7'b1100001};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 7'b0001001};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 7'b0000000};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 7'b0000001};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 7'b0000000};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].v, tbl[i].e, tbl[i].b);
            chk($sformatf("vec_%0d", i), obs, tbl[i].exp);
        end

        // 0xFF: stuffed zero after the fifth data 1 is removed.
        sync_seq();
        for (int i = 0; i < 5; i++) begin
            dec_bit(1'b1);
            chk("ff_head", {data_valid, data_bit, pkt_start}, {2'b11, (i == 0)});
        end
        dec_bit(1'b0);
        chk("ff_stuff_gap", {data_valid, stuff_err}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            dec_bit(1'b1);
            chk("ff_tail", {data_valid, data_bit, pkt_start, stuff_err}, 4'b1100);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("ff_end", {pkt_end, align_err, stuff_err}, 3'b100);
        end_pkt();

        // Stuff violation: a 1 where the stuffed 0 belongs.
        sync_seq();
        repeat (5) dec_bit(1'b1);
        dec_bit(1'b1);
        chk("viol_bit", {data_valid, stuff_err, busy}, {1'b0, ERR, 1'b1});
        for (int i = 0; i < 3; i++) begin
            b = (i != 1);
            dec_bit(b);
            chk("viol_after", {data_valid, stuff_err}, {!ERR, 1'b0});
        end
        step(1'b0, 1'b1, 1'b0);
        chk("viol_end", {pkt_end, align_err}, {!ERR, 1'b0});
        end_pkt();

        // SYNC with only four zeros: dropped.
        lvl = 1'b1;
        repeat (4) dec_bit(1'b0);
        dec_bit(1'b1);
        chk("short_sync_busy", busy, 1'b1);
        dec_bit(1'b0);
        chk("short_sync_nodata", {data_valid, pkt_start}, 2'b00);
        dec_bit(1'b1);
        chk("short_sync_nodata2", {data_valid, pkt_start}, 2'b00);
        step(1'b0, 1'b1, 1'b0);
        chk("short_sync_eop", {pkt_end, busy}, 2'b01);
        end_pkt();

        // Zero-data packet.
        sync_seq();
        step(1'b0, 1'b1, 1'b0);
        chk("empty_pkt", {pkt_start, pkt_end, align_err}, 3'b010);
        end_pkt();

        // 11 data bits with a hold cycle, then a clean 0x00 packet.
        sync_seq();
        for (int i = 0; i < 11; i++) begin
            if (i == 4) begin
                step(1'b0, 1'b0, lvl);
                chk("hold_cycle", {data_valid, pkt_start}, 2'b00);
            end
            b = (i % 2 == 0);
            dec_bit(b);
            chk("b11_data", {data_valid, data_bit}, {1'b1, b});
        end
        step(1'b0, 1'b1, 1'b0);
        chk("b11_end", {pkt_end, align_err}, {1'b1, ERR});
        end_pkt();

        sync_seq();
        for (int i = 0; i < 8; i++) begin
            dec_bit(1'b0);
            chk("zero_data", {data_valid, data_bit, pkt_start}, {2'b10, (i == 0)});
        end
        step(1'b0, 1'b1, 1'b0);
        chk("zero_end", {pkt_end, align_err}, 2'b10);
        end_pkt();

        // Reset after three data bits, then a full packet.
        sync_seq();
        repeat (3) dec_bit(1'b1);
        chk("pre_rst_dv", data_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async", obs, 7'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        chk("post_rst_idle", obs, 7'b0);

        byte_v = 8'hA5;
        sync_seq();
        for (int i = 0; i < 8; i++) begin
            dec_bit(byte_v[i]);
            chk("post_rst_data", {data_valid, data_bit, pkt_start}, {1'b1, byte_v[i], (i == 0)});
        end
        step(1'b0, 1'b1, 1'b0);
        chk("post_rst_end", {pkt_end, align_err}, 2'b10);
        end_pkt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
